// File: rtl/fifo_rd_port_if.sv
// fifo_rd_port_if: signal bundle between a FIFO read port and its environment.
//   rd_en      consumer read request
//   wr_ptr     write pointer from the write side ([2:0] slot, [3] wrap bit)
//   mem_data   8 slots x 3 bits of storage, slot n at [3n+2:3n]
//   rd_ptr     read pointer ([2:0] slot, [3] wrap bit)
//   dout       registered read data
//   dout_valid one-cycle pulse marking new dout
//   empty      no entries stored
//   count      stored entries, 0..8
//   underflow  sticky: read requested while empty
//   ptr_err    sticky: pointer distance exceeded depth
// The slave modport is the read port itself, and the master modport is its environment.
interface fifo_rd_port_if;
    logic        rd_en;
    logic [3:0]  wr_ptr;
    logic [23:0] mem_data;
    logic [3:0]  rd_ptr;
    logic [2:0]  dout;
    logic        dout_valid;
    logic        empty;
    logic [3:0]  count;
    logic        underflow;
    logic        ptr_err;

    modport slave (
        input  rd_en, wr_ptr, mem_data,
        output rd_ptr, dout, dout_valid, empty, count, underflow, ptr_err
    );

    modport master (
        output rd_en, wr_ptr, mem_data,
        input  rd_ptr, dout, dout_valid, empty, count, underflow, ptr_err
    );
endinterface

// File: rtl/fifo_rd_port.sv
// fifo_rd_port: read side of an 8-deep, 3-bit-wide FIFO.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    fifo_rd_port_if.slave (rd_en, wr_ptr, mem_data in;
//          rd_ptr, dout, dout_valid, empty, count, underflow, ptr_err out)
// A read is accepted when rd_en=1, the FIFO is not empty, and the pointer
// distance is sane. The data appears on dout with dout_valid one cycle later.
module fifo_rd_port (
    input  logic           clk,
    input  logic           reset,
    fifo_rd_port_if.slave  bus
);
    localparam int PW    = 4;
    localparam int AW    = 3;
    localparam int DW    = 3;
    localparam int DEPTH = 8;

    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            rd_ptr_inc;
    logic [PW-1:0]            carry;
    logic [PW-1:0]            count_c;
    logic [DEPTH-1:0][DW-1:0] mem_v;
    logic [DW-1:0]            slot;
    logic [DW-1:0]            dout_q;
    logic                     dout_valid_q;
    logic                     underflow_q;
    logic                     ptr_err_q;
    logic                     empty_c;
    logic                     ptr_bad;
    logic                     accept;

    // Empty and full are told apart by the wrap bit, so the distance mod 16 is the count.
    assign count_c = bus.wr_ptr - rd_ptr_q;
    assign empty_c = (rd_ptr_q == bus.wr_ptr);
    // A distance above DEPTH cannot come from a legal write pointer.
    assign ptr_bad = (count_c > PW'(DEPTH));
    assign accept  = bus.rd_en && !empty_c && !ptr_bad;

    assign mem_v = bus.mem_data;
    assign slot  = mem_v[rd_ptr_q[AW-1:0]];

    // Ripple incrementer. The carry out of bit 2 toggles the wrap bit.
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < PW; i++) begin : g_inc
        assign rd_ptr_inc[i] = rd_ptr_q[i] ^ carry[i];
        if (i < PW - 1) begin : g_carry
            assign carry[i+1] = rd_ptr_q[i] & carry[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            ptr_err_q    <= 1'b0;
        end else begin
            dout_valid_q <= accept;
            if (accept) begin
                rd_ptr_q <= rd_ptr_inc;
                dout_q   <= slot;
            end
            if (bus.rd_en && empty_c) underflow_q <= 1'b1;
            if (ptr_bad)              ptr_err_q   <= 1'b1;
        end
    end

    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.empty      = empty_c;
    assign bus.count      = count_c;
    assign bus.underflow  = underflow_q;
    assign bus.ptr_err    = ptr_err_q;
endmodule

// File: tb/tb_fifo_rd_port.sv
// tb_fifo_rd_port: scoreboard bench for fifo_rd_port. The driver pushes the
// hand-computed dout of every read it expects to be accepted, and a negedge
// monitor pops one entry per dout_valid pulse.
module tb_fifo_rd_port;
    logic clk = 1'b0;
    logic reset;
    fifo_rd_port_if bus ();

    fifo_rd_port dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q [$];
    logic [7:0][2:0] m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect this edge's read to be accepted and return value v. rd_en stays high.
    task automatic read_expect(input logic [2:0] v);
        exp_q.push_back(v);
        bus.rd_en = 1'b1;
        tick();
    endtask

    // Monitor: one scoreboard entry is consumed per dout_valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_dout_valid: got dout %0h expected no pulse", bus.dout);
                end else begin
                    chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.rd_en    = 1'b0;
        bus.wr_ptr   = 4'd0;
        bus.mem_data = '0;
        m            = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset_rd_ptr", 32'(bus.rd_ptr), 32'h0);
        chk("in_reset_dout_valid", 32'(bus.dout_valid), 32'h0);
        #2 reset = 1'b0;
        tick();

        // Reset then idle.
        chk("idle_empty", 32'(bus.empty), 32'h1);
        chk("idle_count", 32'(bus.count), 32'h0);
        chk("idle_dout", 32'(bus.dout), 32'h0);
        chk("idle_underflow", 32'(bus.underflow), 32'h0);
        chk("idle_ptr_err", 32'(bus.ptr_err), 32'h0);

        // Single read of slot0 = 101.
        m[0] = 3'b101;
        bus.mem_data = m;
        bus.wr_ptr = 4'd1;
        #1;
        chk("single_count_pre", 32'(bus.count), 32'h1);
        chk("single_empty_pre", 32'(bus.empty), 32'h0);
        read_expect(3'b101);
        bus.rd_en = 1'b0;
        chk("single_dout", 32'(bus.dout), 32'h5);
        chk("single_rd_ptr", 32'(bus.rd_ptr), 32'h1);
        chk("single_empty", 32'(bus.empty), 32'h1);
        chk("single_count", 32'(bus.count), 32'h0);
        tick();
        chk("single_pulse_one_cycle", 32'(bus.dout_valid), 32'h0);
        chk("single_dout_hold", 32'(bus.dout), 32'h5);

        // Walk to rd_ptr=7, then cross the 7->0 wrap.
        m = {3'b011, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b110};
        bus.mem_data = m;
        bus.wr_ptr = 4'd7;
        read_expect(3'b001);
        read_expect(3'b010);
        read_expect(3'b011);
        read_expect(3'b100);
        read_expect(3'b101);
        read_expect(3'b110);
        bus.rd_en = 1'b0;
        chk("walk_rd_ptr", 32'(bus.rd_ptr), 32'h7);
        bus.wr_ptr = 4'b1001;
        read_expect(3'b011);
        chk("wrap_rd_ptr_1", 32'(bus.rd_ptr), 32'h8);
        read_expect(3'b110);
        bus.rd_en = 1'b0;
        chk("wrap_rd_ptr_2", 32'(bus.rd_ptr), 32'h9);
        chk("wrap_empty", 32'(bus.empty), 32'h1);

        // Underflow: a read while empty only sets the sticky flag.
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("uf_flag", 32'(bus.underflow), 32'h1);
        chk("uf_rd_ptr", 32'(bus.rd_ptr), 32'h9);
        chk("uf_dout", 32'(bus.dout), 32'h6);
        chk("uf_dout_valid", 32'(bus.dout_valid), 32'h0);
        tick();
        tick();
        chk("uf_sticky", 32'(bus.underflow), 32'h1);

        // Reset between edges clears everything at once.
        #2 reset = 1'b1;
        #1;
        chk("rst_async_underflow", 32'(bus.underflow), 32'h0);
        chk("rst_async_rd_ptr", 32'(bus.rd_ptr), 32'h0);
        chk("rst_async_dout", 32'(bus.dout), 32'h0);
        bus.wr_ptr = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset lands on a pending read, and the read must vanish.
        for (int i = 0; i < 8; i++) m[i] = 3'(7 - i);
        bus.mem_data = m;
        bus.wr_ptr = 4'b1000;
        bus.rd_en = 1'b1;
        #2 reset = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        #2 reset = 1'b0;
        tick();
        chk("abort_rd_ptr", 32'(bus.rd_ptr), 32'h0);
        chk("abort_dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("drain_count_pre", 32'(bus.count), 32'h8);

        // Full drain: 8 reads of slots 0..7, then 2 underflow edges.
        read_expect(3'd7);
        read_expect(3'd6);
        read_expect(3'd5);
        read_expect(3'd4);
        read_expect(3'd3);
        read_expect(3'd2);
        read_expect(3'd1);
        read_expect(3'd0);
        tick();
        tick();
        bus.rd_en = 1'b0;
        chk("drain_rd_ptr", 32'(bus.rd_ptr), 32'h8);
        chk("drain_empty", 32'(bus.empty), 32'h1);
        chk("drain_underflow", 32'(bus.underflow), 32'h1);

        // Corrupt distance (10) blocks reads and raises ptr_err.
        #2 reset = 1'b1;
        bus.wr_ptr = 4'b1010;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("corrupt_count", 32'(bus.count), 32'ha);
        bus.rd_en = 1'b1;
        tick();
        tick();
        bus.rd_en = 1'b0;
        chk("corrupt_ptr_err", 32'(bus.ptr_err), 32'h1);
        chk("corrupt_rd_ptr", 32'(bus.rd_ptr), 32'h0);
        chk("corrupt_no_underflow", 32'(bus.underflow), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("corrupt_rst_ptr_err", 32'(bus.ptr_err), 32'h0);
        chk("corrupt_rst_dout_valid", 32'(bus.dout_valid), 32'h0);
        bus.wr_ptr = 4'd0;
        #1;
        chk("post_rst_empty", 32'(bus.empty), 32'h1);
        chk("post_rst_count", 32'(bus.count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_rd_port.md
FIFO_RD_PORT -- requirements
Module: fifo_rd_port

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rd_en  input  1  read request from the consumer
- wr_ptr  input  4  write pointer from the write side; [2:0] is the slot address, [3] is the wrap bit
- mem_data  input  24  8 storage slices x 3 bits; slot n occupies bits [3n+2:3n]
- rd_ptr  output  4  read pointer; [2:0] is the slot address, [3] is the wrap bit
- dout  output  3  registered read data
- dout_valid  output  1  one-cycle pulse marking new data on dout
- empty  output  1  FIFO holds no entries
- count  output  4  number of stored entries, 0..8
- underflow  output  1  sticky error flag
- ptr_err  output  1  sticky pointer-corruption flag

Function
REQ-003 empty SHALL be combinational and equal 1 exactly when rd_ptr == wr_ptr on all 4 bits.
REQ-004 count SHALL be combinational and equal (wr_ptr - rd_ptr) mod 16.
REQ-005 A read SHALL be accepted on a rising clk edge when rd_en=1 and empty=0.
REQ-006 On an accepted read, dout SHALL load the 3-bit slice mem_data addressed by the pre-increment rd_ptr[2:0].
REQ-007 On an accepted read, dout_valid SHALL be 1 for the following cycle only.
REQ-008 On an accepted read, rd_ptr SHALL increment by 1 modulo 16; wrap 7->0 of [2:0] SHALL toggle [3].
REQ-009 Latency SHALL be one cycle, from the rd_en sample edge to dout/dout_valid.
REQ-010 Back-to-back reads SHALL be supported at one per cycle while empty=0.
REQ-011 With no accepted read, rd_ptr and dout SHALL hold, and dout_valid SHALL be 0.
REQ-012 When rd_en=1 and empty=1 at an edge, underflow SHALL be set and remain 1 until reset; rd_ptr, dout and dout_valid SHALL behave as in REQ-011.
REQ-013 When count > 8 at an edge, ptr_err SHALL be set and remain 1 until reset; reads SHALL be blocked while count > 8.
REQ-014 wr_ptr SHALL be treated as synchronous to clk and sampled only at clk edges.
REQ-015 A write and a read in the same cycle SHALL both take effect:
- empty and count SHALL reflect the new wr_ptr in the next cycle.
- A read is never accepted on a slot whose write is only now arriving (empty=1 blocks it).
REQ-016 The pointer SHALL be built as a ripple-increment register: xor/and carry chain over 4 bits.
REQ-017 The output register SHALL be a 3-bit load-enabled register, with load = accepted read.

Reset
REQ-018 While reset=1, regardless of clk, the outputs SHALL be: rd_ptr=0, dout=0, dout_valid=0, underflow=0, ptr_err=0.
REQ-019 Reset asserted mid-read SHALL abort the read:
- No dout_valid pulse SHALL follow deassertion.
- The first edge after deassertion SHALL behave normally.
REQ-020 After reset with wr_ptr=0, empty SHALL be 1 and count SHALL be 0.

Verification
REQ-021 Reset then idle:
- wr_ptr=0, rd_en=0 -> empty=1, count=0, dout=0, all flags 0.
REQ-022 Single read:
- Setup: mem_data slot0=3'b101, wr_ptr=1; pulse rd_en one cycle.
- Response next cycle: dout=3'b101, dout_valid=1; then rd_ptr=1, empty=1, count=0.
REQ-023 Wrap-around:
- Setup: rd_ptr=4'b0111, wr_ptr=4'b1001, slot7=3'b011, slot0=3'b110; rd_en=1 for two cycles.
- Response: dout=011 then 110; rd_ptr=4'b1000 then 4'b1001; empty=1.
REQ-024 Underflow:
- Stimulus: rd_en=1 while empty.
- Response: underflow=1 sticky, dout_valid=0, rd_ptr unchanged; cleared only by reset.
REQ-025 Full drain:
- Setup: wr_ptr=4'b1000 with rd_ptr=0 (count=8); rd_en held 10 cycles.
- Response: exactly 8 dout_valid pulses carrying slots 0..7 in order, then underflow=1.
REQ-026 Corruption and reset:
- wr_ptr=4'b1010 with rd_ptr=0 -> ptr_err=1 and reads blocked.
- Reset asserted between clk edges -> all outputs 0 immediately.
